// File: rtl/rv_rf_pkg.sv
// Shared constants and FSM state type for the register-file operand fetch slice.
package rv_rf_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } of_state_e;

endpackage

// File: rtl/rv_rf_operand_fetch_scoreboard.sv
// Pending-write tracker: one bit per register, raises hazard on RAW to a pending source.
module rv_rf_scoreboard #(
  parameter int AW = rv_rf_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic          rs1_en,
  input  logic [AW-1:0] rs1,
  input  logic          rs2_en,
  input  logic [AW-1:0] rs2,
  output logic          hazard
);

  localparam int N = 1 << AW;

  logic [N-1:0] pending;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic         hz1;
  logic         hz2;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && (set_idx != '0))
      set_vec[set_idx] = 1'b1;
    if (clr_en)
      clr_vec[clr_idx] = 1'b1;
  end

  // set is OR-ed after the clear so a same-cycle set wins
  always_ff @(posedge clk) begin
    if (reset)
      pending <= '0;
    else
      pending <= (pending & ~clr_vec) | set_vec;
  end

  assign hz1 = rs1_en && pending[rs1]
            && !(clr_en && (clr_idx == rs1));
  assign hz2 = rs2_en && pending[rs2]
            && !(clr_en && (clr_idx == rs2));
  assign hazard = hz1 || hz2;

endmodule

// File: rtl/rv_rf_operand_fetch.sv
// Operand fetch between decode and execute; drives RF read/write ports.
// Define RF_SCOREBOARD_EN to stall issue on read-after-write hazards.
module rv_rf_operand_fetch #(
  parameter int XLEN = rv_rf_pkg::XLEN,
  parameter int AW   = rv_rf_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_rs1_en,
  input  logic            iss_rs2_en,
  input  logic            iss_rd_en,
  output logic            re1,
  output logic            re2,
  output logic [AW-1:0]   raddr1,
  output logic [AW-1:0]   raddr2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [AW-1:0]   op_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wr,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata
);

  import rv_rf_pkg::*;

  of_state_e state;
  of_state_e state_nx;
  logic      accept;
  logic      hazard;
  logic      ld_ops;

`ifdef RF_SCOREBOARD_EN
  rv_rf_scoreboard #(
    .AW(AW)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && iss_rd_en),
    .set_idx (iss_rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .rs1_en  (iss_rs1_en),
    .rs1     (iss_rs1),
    .rs2_en  (iss_rs2_en),
    .rs2     (iss_rs2),
    .hazard  (hazard)
  );
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    iss_ready = 1'b0;
    ld_ops    = 1'b0;
    unique case (state)
      IDLE: begin
        iss_ready = !reset && !hazard;
        if (iss_valid && iss_ready)
          state_nx = READ;
      end
      READ: begin
        ld_ops   = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (op_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = iss_valid && iss_ready;

  assign re1    = accept && iss_rs1_en;
  assign re2    = accept && iss_rs2_en;
  assign raddr1 = accept ? iss_rs1 : '0;
  assign raddr2 = accept ? iss_rs2 : '0;

  // x0 writes are dropped here so the RF never sees them
  assign wr    = wb_valid && (wb_rd != '0);
  assign waddr = wb_rd;
  assign wdata = wb_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_rd    <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        op_rd <= iss_rd_en ? iss_rd : '0;
      if (ld_ops) begin
        op_a     <= rdata1;
        op_b     <= rdata2;
        op_valid <= 1'b1;
      end else if ((state == HOLD) && op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv_rf_operand_fetch.sv
// Bench for rv_rf_operand_fetch: behavioural RF model plus expected-result queue.
`timescale 1ns/1ps
module tb_rv_rf_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rs1_en, iss_rs2_en, iss_rd_en;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] rf [32];
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  rv_rf_operand_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_rd     (iss_rd),
    .iss_rs1_en (iss_rs1_en),
    .iss_rs2_en (iss_rs2_en),
    .iss_rd_en  (iss_rd_en),
    .re1        (re1),
    .re2        (re2),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_rd      (op_rd),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wr         (wr),
    .waddr      (waddr),
    .wdata      (wdata)
  );

  // register file: registered read, x0 reads zero, write-through
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[3] = 32'h11;
    rf[4] = 32'h22;
  end

  always @(posedge clk) begin
    rdata1 <= (re1 && raddr1 != 5'd0)
            ? ((wr && waddr == raddr1) ? wdata : rf[raddr1]) : '0;
    rdata2 <= (re2 && raddr2 != 5'd0)
            ? ((wr && waddr == raddr2) ? wdata : rf[raddr2]) : '0;
    if (wr) rf[waddr] <= wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && op_valid && op_ready) begin
      if (exp_q.size() == 0) begin
        chk("q_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("op_a", op_a, mon_e.a);
        chk("op_b", op_b, mon_e.b);
        chk("op_rd", 32'(op_rd), 32'(mon_e.rd));
      end
    end
  end

  task automatic drive_iss(input logic r1e, input logic [4:0] r1,
                           input logic r2e, input logic [4:0] r2,
                           input logic rde, input logic [4:0] rd);
    iss_rs1_en = r1e; iss_rs1 = r1;
    iss_rs2_en = r2e; iss_rs2 = r2;
    iss_rd_en  = rde; iss_rd  = rd;
    iss_valid  = 1'b1;
    #1;
  endtask

  task automatic wait_ready(input int maxw);
    int w = 0;
    while (!iss_ready && w < maxw) begin
      @(posedge clk); #1;
      w++;
    end
    chk("iss_ready_wait", 32'(iss_ready), 32'd1);
  endtask

  // accept edge is the next posedge; op_valid must rise two edges later
  task automatic take(input logic [31:0] ea, input logic [31:0] eb,
                      input logic [4:0] erd);
    exp_t e;
    chk("re1", 32'(re1), 32'(iss_rs1_en));
    chk("re2", 32'(re2), 32'(iss_rs2_en));
    chk("raddr1", 32'(raddr1), 32'(iss_rs1));
    chk("raddr2", 32'(raddr2), 32'(iss_rs2));
    e.a = ea; e.b = eb; e.rd = erd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
    chk("ov_n1", 32'(op_valid), 32'd0);
    chk("rdy_read", 32'(iss_ready), 32'd0);
    @(posedge clk); #1;
    chk("ov_n2", 32'(op_valid), 32'd1);
  endtask

  task automatic issue(input logic r1e, input logic [4:0] r1,
                       input logic r2e, input logic [4:0] r2,
                       input logic rde, input logic [4:0] rd,
                       input logic [31:0] ea, input logic [31:0] eb);
    drive_iss(r1e, r1, r2e, r2, rde, rd);
    wait_ready(10);
    take(ea, eb, rde ? rd : 5'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    iss_rs1_en = 0; iss_rs2_en = 0; iss_rd_en = 0;
    op_ready = 1'b1;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    #1;
    iss_valid = 1'b1;
    iss_rs1_en = 1'b1; iss_rs1 = 5'd3;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    #1;
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_op_rd", 32'(op_rd), 32'd0);
    chk("rst_iss_ready", 32'(iss_ready), 32'd0);
    chk("rst_re1", 32'(re1), 32'd0);
    chk("rst_wr", 32'(wr), 32'd1);
    chk("rst_waddr", 32'(waddr), 32'd9);
    chk("rst_wdata", wdata, 32'h99);
    @(posedge clk); #1;
    reset = 1'b0;
    iss_valid = 1'b0;
    wb_valid = 1'b0;
    #1;
    chk("rdy_idle", 32'(iss_ready), 32'd1);

    issue(1, 5'd3, 1, 5'd4, 0, 5'd0, 32'h11, 32'h22);
    issue(0, 5'd3, 1, 5'd4, 1, 5'd7, 32'h0, 32'h22);

    issue(1, 5'd3, 1, 5'd4, 1, 5'd5, 32'h11, 32'h22);
    drive_iss(1, 5'd5, 0, 5'd0, 0, 5'd0);
`ifdef RF_SCOREBOARD_EN
    repeat (3) begin
      chk("hz_stall", 32'(iss_ready), 32'd0);
      chk("hz_re1", 32'(re1), 32'd0);
      @(posedge clk); #1;
    end
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD;
    #1;
    chk("hz_release", 32'(iss_ready), 32'd1);
    take(32'hDEAD, 32'h0, 5'd0);
    @(posedge clk); #1;
`else
    chk("no_sb_rdy", 32'(iss_ready), 32'd1);
    take(32'h0, 32'h0, 5'd0);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD;
    @(posedge clk); #1;
    wb_valid = 1'b0;
`endif

    op_ready = 1'b0;
    drive_iss(1, 5'd4, 1, 5'd3, 1, 5'd9);
    wait_ready(10);
    take(32'h22, 32'h11, 5'd9);
    repeat (4) begin
      chk("hold_valid", 32'(op_valid), 32'd1);
      chk("hold_a", op_a, 32'h22);
      chk("hold_b", op_b, 32'h11);
      chk("hold_rd", 32'(op_rd), 32'd9);
      chk("hold_rdy", 32'(iss_ready), 32'd0);
      @(posedge clk); #1;
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_valid", 32'(op_valid), 32'd0);
    chk("drain_idle", 32'(iss_ready), 32'd1);

    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
    #1;
    chk("wb_x0_wr", 32'(wr), 32'd0);
    @(posedge clk); #1;
    wb_rd = 5'd9; wb_data = 32'h99;
    #1;
    chk("wb9_wr", 32'(wr), 32'd1);
    chk("wb9_waddr", 32'(waddr), 32'd9);
    chk("wb9_wdata", wdata, 32'h99);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    issue(1, 5'd0, 1, 5'd9, 0, 5'd0, 32'h0, 32'h99);

    op_ready = 1'b0;
    drive_iss(1, 5'd4, 0, 5'd0, 1, 5'd5);
    wait_ready(10);
    take(32'h22, 32'h0, 5'd5);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("hrst_valid", 32'(op_valid), 32'd0);
    chk("hrst_a", op_a, 32'd0);
    chk("hrst_b", op_b, 32'd0);
    chk("hrst_rd", 32'(op_rd), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    op_ready = 1'b1;
    drive_iss(1, 5'd5, 0, 5'd0, 0, 5'd0);
    chk("post_rst_rdy", 32'(iss_ready), 32'd1);
    take(32'hDEAD, 32'h0, 5'd0);
    @(posedge clk); #1;
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
